// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the BCD<->binary converters.
package bcd_pkg;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;
endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step for decimal conversion: acc*10 + d, with a digit range check.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] d,
  output logic [OUT_W-1:0]   acc_nxt,
  output logic               invalid
);
  // x10 as shift-and-add keeps this a pair of adders rather than a multiplier
  assign acc_nxt = (acc << 3) + (acc << 1) + OUT_W'(d);
  assign invalid = (d > DIGIT_W'(MAX_DIGIT));
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, MS digit first, one digit per clock.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W-1:0]          data,
  output logic                      err
);
  localparam int unsigned IN_W  = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_e         state_q, state_d;
  logic [IN_W-1:0]    sh_q;
  logic [OUT_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               errf_q, dig_bad, err_all;
  logic               load, step, last;

  bcd_digit_mac #(.OUT_W(OUT_W)) u_mac (
    .acc     (acc_q),
    .d       (sh_q[IN_W-1 -: DIGIT_W]),
    .acc_nxt (acc_nxt),
    .invalid (dig_bad)
  );

  assign last    = (cnt_q == CNT_W'(DIGITS-1));
  assign err_all = errf_q | dig_bad;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CONV;
        load    = 1'b1;
      end
      CONV: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        // back-to-back: a start seen in DONE goes straight into the next conversion
        state_d = start ? CONV : IDLE;
        load    = start;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      errf_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      data   <= '0;
      err    <= 1'b0;
    end else begin
      busy <= (state_d == CONV);
      done <= step && last;
      if (load) begin
        sh_q   <= bcd;
        acc_q  <= '0;
        cnt_q  <= '0;
        errf_q <= 1'b0;
      end else if (step) begin
        sh_q   <= sh_q << DIGIT_W;
        acc_q  <= acc_nxt;
        cnt_q  <= cnt_q + 1'b1;
        errf_q <= err_all;
        if (last) begin
          data <= err_all ? '0 : acc_nxt;
          err  <= err_all;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=8, OUT_W=32).
module tb_bcd_to_bin;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bcd;
  logic        busy, done, err;
  logic [31:0] data;
  int          total = 0;
  int          bad   = 0;

  bcd_to_bin #(.DIGITS(8), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .data(data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion from IDLE: checks busy/done every cycle and the result at done.
  task automatic conv(input logic [31:0] word, input logic [31:0] exp_data,
                      input logic exp_err, input bit scramble, input bit toggle);
    @(negedge clk);
    bcd   = word;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("done_after_start", {31'b0, done}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      if (scramble) bcd = $urandom;
      if (toggle && i < 7) start = i[0];
      else start = 1'b0;
      @(posedge clk); #1;
      if (i < 8) begin
        check("busy_conv", {31'b0, busy}, 32'd1);
        check("done_early", {31'b0, done}, 32'd0);
      end
    end
    start = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("data", data, exp_data);
    check("err", {31'b0, err}, {31'b0, exp_err});
    @(posedge clk); #1;
    check("done_drop", {31'b0, done}, 32'd0);
    check("data_hold", data, exp_data);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_err",  {31'b0, err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    conv(32'h12345678, 32'h00BC614E, 1'b0, 1'b0, 1'b0);
    conv(32'h99999999, 32'h05F5E0FF, 1'b0, 1'b0, 1'b0);
    conv(32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    conv(32'h1234A678, 32'h00000000, 1'b1, 1'b0, 1'b0);
    conv(32'h00000055, 32'd55,       1'b0, 1'b0, 1'b0);
    conv(32'h00031415, 32'd31415,    1'b0, 1'b1, 1'b0);
    conv(32'h00000909, 32'd909,      1'b0, 1'b0, 1'b1);

    // start held high: done every 9 cycles, second word presented during DONE
    @(negedge clk);
    bcd   = 32'h00000042;
    start = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    check("b2b_done1", {31'b0, done}, 32'd1);
    check("b2b_data1", data, 32'd42);
    bcd = 32'h00000007;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_gap", {31'b0, done}, 32'd0);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("b2b_done2", {31'b0, done}, 32'd1);
    check("b2b_data2", data, 32'd7);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_done", {31'b0, done}, 32'd0);
    check("b2b_idle_busy", {31'b0, busy}, 32'd0);

    // asynchronous reset 4 cycles into a conversion
    @(negedge clk);
    bcd   = 32'h87654321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_data", data, 32'd0);
    check("arst_err",  {31'b0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_no_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("post_rst_idle_done", {31'b0, done}, 32'd0);
    check("post_rst_idle_busy", {31'b0, busy}, 32'd0);
    conv(32'h00000100, 32'd100, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
